// File: rtl/soc_ifc_fw_upd_rst_req.sv
// Sequences a firmware FW_UPDATE_RESET write into a single fw_update_rst request:
// wait for bus idle, drain, assert until the boot FSM opens its window, then release.
module soc_ifc_fw_upd_rst_req #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT  = 32,
    parameter int unsigned MIN_WAIT     = 5,
    localparam int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             cptra_rst_b,
    input  logic             req_wr,
    input  logic             req_wdata,
    input  logic             wait_wr,
    input  logic [CNT_W-1:0] wait_wdata,
    input  logic             core_idle,
    input  logic             fw_update_rst_window,
    input  logic             err_clr,
    output logic             fw_update_rst,
    output logic [CNT_W-1:0] fw_update_rst_wait_cycles,
    output logic             req_status,
    output logic             busy,
    output logic             err_overlap,
    output logic             err_timeout
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WAIT_FLOOR = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ASSERT = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;

    logic [CNT_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0] w_drain_cnt_nxt;
    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] w_tmo_cnt_nxt;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0] w_wait_clamp;

    logic             r_fw_rst;
    logic             w_fw_rst_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_err_overlap;
    logic             w_err_overlap_nxt;
    logic             r_err_timeout;
    logic             w_err_timeout_nxt;

    logic             w_req_set;
    logic             w_set_overlap;
    logic             w_set_timeout;

    assign w_req_set    = req_wr & req_wdata;
    assign w_wait_clamp = (wait_wdata < WAIT_FLOOR) ? WAIT_FLOOR : wait_wdata;

    // State register
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a bus-idle drop during drain wins over drain completion
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req_set) w_state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (core_idle) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!core_idle)                   w_state_nxt = ST_ARM;
                else if (r_drain_cnt == CNT_ZERO) w_state_nxt = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (fw_update_rst_window)       w_state_nxt = ST_HOLD;
                else if (r_tmo_cnt == CNT_ZERO) w_state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (!fw_update_rst_window) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counters, wait register, error sets and next values of registered outputs
    always_comb begin
        w_drain_cnt_nxt = r_drain_cnt;
        w_tmo_cnt_nxt   = r_tmo_cnt;
        w_wait_nxt      = r_wait;
        w_set_overlap   = 1'b0;
        w_set_timeout   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (wait_wr) w_wait_nxt = w_wait_clamp;
            end
            ST_ARM: begin
                if (core_idle) w_drain_cnt_nxt = DRAIN_LOAD;
            end
            ST_DRAIN: begin
                if (!core_idle) begin
                    w_drain_cnt_nxt = CNT_ZERO;
                end else if (r_drain_cnt != CNT_ZERO) begin
                    w_drain_cnt_nxt = r_drain_cnt - CNT_ONE;
                end else begin
                    w_tmo_cnt_nxt = TMO_LOAD;
                end
            end
            ST_ASSERT: begin
                if (fw_update_rst_window) begin
                    w_tmo_cnt_nxt = CNT_ZERO;
                end else if (r_tmo_cnt != CNT_ZERO) begin
                    w_tmo_cnt_nxt = r_tmo_cnt - CNT_ONE;
                end else begin
                    w_set_timeout = 1'b1;
                end
            end
            ST_HOLD: begin
                w_tmo_cnt_nxt = CNT_ZERO;
            end
            default: begin
                w_drain_cnt_nxt = CNT_ZERO;
                w_tmo_cnt_nxt   = CNT_ZERO;
            end
        endcase

        // Any request or wait write outside IDLE is dropped and flagged
        if (r_state != ST_IDLE) begin
            w_set_overlap = wait_wr | w_req_set;
        end

        w_fw_rst_nxt      = (w_state_nxt == ST_ASSERT);
        w_busy_nxt        = (w_state_nxt != ST_IDLE);
        w_err_overlap_nxt = w_set_overlap | (r_err_overlap & ~err_clr);
        w_err_timeout_nxt = w_set_timeout | (r_err_timeout & ~err_clr);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_drain_cnt   <= CNT_ZERO;
            r_tmo_cnt     <= CNT_ZERO;
            r_wait        <= WAIT_FLOOR;
            r_fw_rst      <= 1'b0;
            r_busy        <= 1'b0;
            r_err_overlap <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_drain_cnt   <= w_drain_cnt_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_wait        <= w_wait_nxt;
            r_fw_rst      <= w_fw_rst_nxt;
            r_busy        <= w_busy_nxt;
            r_err_overlap <= w_err_overlap_nxt;
            r_err_timeout <= w_err_timeout_nxt;
        end
    end

    assign fw_update_rst             = r_fw_rst;
    assign fw_update_rst_wait_cycles = r_wait;
    assign req_status                = r_busy;
    assign busy                      = r_busy;
    assign err_overlap               = r_err_overlap;
    assign err_timeout               = r_err_timeout;

endmodule

// File: tb/tb_soc_ifc_fw_upd_rst_req.sv
// Scoreboard bench for soc_ifc_fw_upd_rst_req: stimulus queues cycle-tagged expected
// output snapshots, a negedge monitor pops and compares them.
module tb_soc_ifc_fw_upd_rst_req;

    localparam int unsigned MIN_WAIT = 5;

    logic       clk = 1'b0;
    logic       cptra_rst_b = 1'b0;
    logic       req_wr = 1'b0;
    logic       req_wdata = 1'b0;
    logic       wait_wr = 1'b0;
    logic [7:0] wait_wdata = 8'd0;
    logic       core_idle = 1'b0;
    logic       window = 1'b0;
    logic       err_clr = 1'b0;
    logic       fw_update_rst;
    logic [7:0] fw_update_rst_wait_cycles;
    logic       req_status;
    logic       busy;
    logic       err_overlap;
    logic       err_timeout;

    soc_ifc_fw_upd_rst_req #(
        .DRAIN_CYCLES(4),
        .ACK_TIMEOUT (32),
        .MIN_WAIT    (MIN_WAIT)
    ) dut (
        .clk                      (clk),
        .cptra_rst_b              (cptra_rst_b),
        .req_wr                   (req_wr),
        .req_wdata                (req_wdata),
        .wait_wr                  (wait_wr),
        .wait_wdata               (wait_wdata),
        .core_idle                (core_idle),
        .fw_update_rst_window     (window),
        .err_clr                  (err_clr),
        .fw_update_rst            (fw_update_rst),
        .fw_update_rst_wait_cycles(fw_update_rst_wait_cycles),
        .req_status               (req_status),
        .busy                     (busy),
        .err_overlap              (err_overlap),
        .err_timeout              (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fw;
        logic [7:0] wc;
        logic       busy;
        logic       eo;
        logic       et;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t v;
    } ent_t;

    ent_t       exp_q[$];
    string      name_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_rise = 0;
    logic       fw_q = 1'b0;
    logic [7:0] e_wc = 8'(MIN_WAIT);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Queue an expected snapshot for the cycle 'off' edges from now
    task automatic chk(input string nm, input int off, input logic fw, input logic bsy,
                       input logic eo, input logic et);
        ent_t e;
        e.cyc = cyc + off;
        e.v   = '{fw: fw, wc: e_wc, busy: bsy, eo: eo, et: et};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk_int(input string nm, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    task automatic req();
        req_wr    = 1'b1;
        req_wdata = 1'b1;
        tick();
        req_wr    = 1'b0;
        req_wdata = 1'b0;
    endtask

    task automatic wr_wait(input logic [7:0] v);
        wait_wr    = 1'b1;
        wait_wdata = v;
        tick();
        wait_wr    = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Monitor: count request pulses and retire every expectation due this cycle
    always @(negedge clk) begin
        obs_t  a;
        ent_t  e;
        string nm;
        a = '{fw: fw_update_rst, wc: fw_update_rst_wait_cycles, busy: busy,
              eo: err_overlap, et: err_timeout};
        if (fw_update_rst && !fw_q) n_rise++;
        fw_q = fw_update_rst;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (e.cyc != cyc || a != e.v || req_status != e.v.busy) begin
                n_fail++;
                $display("FAIL %s @cyc %0d (due %0d): got fw=%b wc=%0d busy=%b status=%b eo=%b et=%b, expected fw=%b wc=%0d busy=%b status=%b eo=%b et=%b",
                         nm, cyc, e.cyc, a.fw, a.wc, a.busy, req_status, a.eo, a.et,
                         e.v.fw, e.v.wc, e.v.busy, e.v.busy, e.v.eo, e.v.et);
            end
        end
    end

    initial begin
        int r0;

        // Reset state
        run(2);
        chk("reset", 0, 0, 0, 0, 0);
        tick();
        cptra_rst_b = 1'b1;
        tick();

        // Basic request with window handshake
        wr_wait(8'd20);
        e_wc = 8'd20;
        chk("wait_20", 0, 0, 0, 0, 0);
        core_idle = 1'b1;
        req();
        chk("basic_arm", 0, 0, 1, 0, 0);
        chk("basic_pre_assert", 4, 0, 1, 0, 0);
        chk("basic_fw_rise", 5, 1, 1, 0, 0);
        run(7);
        window = 1'b1;
        chk("basic_fw_held", 0, 1, 1, 0, 0);
        tick();
        chk("basic_fw_fall", 0, 0, 1, 0, 0);
        run(24);
        window = 1'b0;
        chk("basic_hold", 0, 0, 1, 0, 0);
        tick();
        chk("basic_idle", 0, 0, 0, 0, 0);

        // core_rst=0 write is a no-op
        req_wr = 1'b1;
        tick();
        req_wr = 1'b0;
        chk("nop_req", 0, 0, 0, 0, 0);
        tick();
        chk("nop_req_quiet", 0, 0, 0, 0, 0);

        // Clamp
        wr_wait(8'd2);
        e_wc = 8'd5;
        chk("clamp_2", 0, 0, 0, 0, 0);
        wr_wait(8'd0);
        chk("clamp_0", 0, 0, 0, 0, 0);
        wr_wait(8'd255);
        e_wc = 8'd255;
        chk("clamp_255", 0, 0, 0, 0, 0);

        // Bus busy, then idle drop in the middle of drain
        core_idle = 1'b0;
        req();
        chk("bb_arm", 0, 0, 1, 0, 0);
        for (int k = 1; k <= 11; k++) chk("bb_arm_hold", k, 0, 1, 0, 0);
        run(10);
        core_idle = 1'b1;
        run(3);
        core_idle = 1'b0;
        tick();
        core_idle = 1'b1;
        for (int k = 1; k <= 4; k++) chk("bb_redrain", k, 0, 1, 0, 0);
        chk("bb_assert", 5, 1, 1, 0, 0);
        run(5);
        window = 1'b1;
        tick();
        chk("bb_hold", 0, 0, 1, 0, 0);
        window = 1'b0;
        tick();
        chk("bb_idle", 0, 0, 0, 0, 0);

        // Timeout: exactly 32 cycles of request, then sticky error
        req();
        chk("to_arm", 0, 0, 1, 0, 0);
        chk("to_pre", 4, 0, 1, 0, 0);
        for (int k = 5; k <= 36; k++) chk("to_fw_high", k, 1, 1, 0, 0);
        chk("to_expire", 37, 0, 0, 0, 1);
        run(37);
        tick();
        chk("to_sticky", 0, 0, 0, 0, 1);
        pulse_clr();
        chk("to_clr", 0, 0, 0, 0, 0);
        req();
        chk("to2_last", 36, 1, 1, 0, 0);
        run(36);
        pulse_clr();
        chk("to2_set_wins", 0, 0, 0, 0, 1);
        pulse_clr();
        chk("to2_clr", 0, 0, 0, 0, 0);

        // Overlap during ASSERT
        r0 = n_rise;
        req();
        run(5);
        chk("ov_fw", 0, 1, 1, 0, 0);
        req_wr     = 1'b1;
        req_wdata  = 1'b1;
        wait_wr    = 1'b1;
        wait_wdata = 8'd50;
        tick();
        req_wr    = 1'b0;
        req_wdata = 1'b0;
        wait_wr   = 1'b0;
        chk("ov_flag", 0, 1, 1, 1, 0);
        window = 1'b1;
        tick();
        chk("ov_hold", 0, 0, 1, 1, 0);
        window = 1'b0;
        tick();
        chk("ov_idle", 0, 0, 0, 1, 0);
        for (int k = 1; k <= 6; k++) chk("ov_quiet", k, 0, 0, 1, 0);
        run(6);
        chk_int("ov_single_pulse", n_rise - r0, 1);
        pulse_clr();
        chk("ov_clr", 0, 0, 0, 0, 0);

        // Reset in the middle of ASSERT
        req();
        run(5);
        wr_wait(8'd9);
        chk("rs_pre", 0, 1, 1, 1, 0);
        @(negedge clk);
        #1;
        cptra_rst_b = 1'b0;
        #1;
        chk_int("rs_async_fw", int'(fw_update_rst), 0);
        chk_int("rs_async_busy", int'(busy), 0);
        e_wc = 8'(MIN_WAIT);
        chk("rs_state", 1, 0, 0, 0, 0);
        tick();
        cptra_rst_b = 1'b1;
        tick();
        chk("rs_release", 0, 0, 0, 0, 0);

        // Simultaneous wait write and request after reset
        wait_wr    = 1'b1;
        wait_wdata = 8'd30;
        req();
        wait_wr = 1'b0;
        e_wc = 8'd30;
        chk("rs_sim_arm", 0, 0, 1, 0, 0);
        chk("rs_re_pre", 4, 0, 1, 0, 0);
        chk("rs_re_fw", 5, 1, 1, 0, 0);
        run(5);
        window = 1'b1;
        tick();
        chk("rs_re_hold", 0, 0, 1, 0, 0);
        window = 1'b0;
        tick();
        chk("rs_re_idle", 0, 0, 0, 0, 0);

        run(3);
        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
